// File: rtl/shift_register_serial_ctrl_pkg.sv
// Shared definitions for the serial shift controller: FSM state encoding
// and the bit-counter width helper.
package shift_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Counter must be able to hold the value WIDTH itself (seen during DONE).
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_register_serial_ctrl_if.sv
// Bus bundle for shift_register_serial_ctrl: control/data inputs, shifted
// data, handshake flags, bit counter and FSM state for observation.
interface shift_register_serial_ctrl_if
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) ();
    localparam int CNT_W = cnt_width(WIDTH);

    logic             enable;
    logic             start;
    logic [WIDTH-1:0] d;
    logic             ser_in;
    logic [WIDTH-1:0] q;
    logic             ser_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] bit_cnt;
    state_t           state;

    // Handshake: start is accepted only on an enabled edge while idle or in the
    // done cycle; busy covers the whole transfer, done pulses for exactly one cycle.
    modport master (
        output enable, start, d, ser_in,
        input  q, ser_out, busy, done, bit_cnt, state
    );

    modport slave (
        input  enable, start, d, ser_in,
        output q, ser_out, busy, done, bit_cnt, state
    );

endinterface

// File: rtl/shift_register_serial_ctrl_core.sv
// Datapath of the serial controller: parallel load plus one-bit shift with
// ser_in captured into the vacated end; load wins over shift.
module shift_register_core #(
    parameter int WIDTH     = 16,
    parameter int LSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in,
    output logic [WIDTH-1:0] q,
    output logic             ser_out
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (shift) begin
            if (LSB_FIRST != 0) q <= {ser_in, q[WIDTH-1:1]};
            else                q <= {q[WIDTH-2:0], ser_in};
        end
    end

    assign ser_out = (LSB_FIRST != 0) ? q[0] : q[WIDTH-1];

endmodule

// File: rtl/shift_register_serial_ctrl.sv
// Serial transfer controller: load on start, shift WIDTH bits, pulse done.
// Optional trailing even-parity bit when SHIFTREG_PARITY_EN is defined.
module shift_register_serial_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int LSB_FIRST = 0
) (
    input logic                          clk,
    input logic                          reset,
    shift_register_serial_ctrl_if.slave  bus
);
    localparam int               CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic             load, shift;
    logic             core_ser_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (load)       bit_cnt <= '0;
            else if (shift) bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        shift     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start && bus.enable) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.enable) begin
                    shift = 1'b1;
                    if (bit_cnt == LAST) begin
`ifdef SHIFTREG_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = DONE;
`endif
                    end
                end
            end
`ifdef SHIFTREG_PARITY_EN
            PARITY: begin
                if (bus.enable) state_nxt = DONE;
            end
`endif
            DONE: begin
                // A start here chains straight into the next transfer.
                if (bus.start && bus.enable) begin
                    load      = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    shift_register_core #(
        .WIDTH    (WIDTH),
        .LSB_FIRST(LSB_FIRST)
    ) u_core (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .shift  (shift),
        .d      (bus.d),
        .ser_in (bus.ser_in),
        .q      (bus.q),
        .ser_out(core_ser_out)
    );

`ifdef SHIFTREG_PARITY_EN
    logic par_q;

    always_ff @(posedge clk) begin
        if (reset)     par_q <= 1'b0;
        else if (load) par_q <= ^bus.d;
    end

    assign bus.ser_out = (state == PARITY) ? par_q : core_ser_out;
`else
    assign bus.ser_out = core_ser_out;
`endif

    assign bus.busy    = (state == SHIFT) || (state == PARITY);
    assign bus.done    = (state == DONE);
    assign bus.bit_cnt = bit_cnt;
    assign bus.state   = state;

endmodule
